breath_led_array: RTL and testbench

//  Multi-channel PWM LED driver for board status LEDs. Channel count, PWM resolution and ramp depth are parameters.

---
 rtl/breath_led_pkg.sv | 30 +++
 rtl/breath_led_chan.sv | 120 ++++++++++++
 rtl/breath_led_array.sv | 78 +++++++
 tb/tb_breath_led_array.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/breath_led_pkg.sv
// ---------------------------------------------------------------------------
// breath_led_pkg
// Shared definitions for the breath_led_array LED driver.
//   MODE_OFF / MODE_ON / MODE_BREATH / MODE_BLINK : 2-bit channel mode codes
//   start_value() : initial ramp accumulator value for channel k
// ---------------------------------------------------------------------------
package breath_led_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF    = 2'b00;
    localparam mode_t MODE_ON     = 2'b01;
    localparam mode_t MODE_BREATH = 2'b10;
    localparam mode_t MODE_BLINK  = 2'b11;

    // With phase spreading, channels are staggered evenly over the ramp range
    // so the board LEDs do not pulse in lockstep; otherwise all start at zero.
    function automatic longint unsigned start_value(input int k,
                                                    input int ch_num,
                                                    input int duty_w,
                                                    input bit phase_spread);
        longint unsigned span;
        if (!phase_spread) begin
            return 64'd0;
        end
        span = (64'd1 << duty_w) / 64'(ch_num);
        return 64'(k) * span;
    endfunction

endpackage

// File: rtl/breath_led_chan.sv
// ---------------------------------------------------------------------------
// breath_led_chan
// One LED channel: mode/rate config registers, ramp accumulator with
// direction, peak pulse and the PWM lit compare.
//   i_clk   : system clock
//   i_rst   : synchronous reset, active high
//   i_sync  : realign the ramp to START, direction up
//   i_cnt   : shared PWM counter
//   i_we    : config write strobe already decoded for this channel
//   i_mode  : new mode (OFF/ON/BREATH/BLINK)
//   i_rate  : new ramp rate exponent, step = 1 << rate
//   o_led   : registered LED pin
//   o_peak  : one-cycle pulse when the ramp clamps at MAX
// ---------------------------------------------------------------------------
module breath_led_chan
    import breath_led_pkg::*;
#(
    parameter int                PWM_W      = 8,
    parameter int                DUTY_W     = 21,
    parameter int                RATE_W     = 4,
    parameter int                ACTIVE_LOW = 1,
    parameter logic [DUTY_W-1:0] START      = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sync,
    input  logic [PWM_W-1:0]  i_cnt,
    input  logic              i_we,
    input  logic [1:0]        i_mode,
    input  logic [RATE_W-1:0] i_rate,
    output logic              o_led,
    output logic              o_peak
);

    localparam logic [DUTY_W-1:0] MAX    = '1;
    localparam logic              LOW_ON = (ACTIVE_LOW != 0);

    mode_t             mode;
    logic [RATE_W-1:0] rate;
    logic [DUTY_W-1:0] duty;
    logic              dir_down;

    logic [RATE_W-1:0] eff_rate;
    logic [DUTY_W-1:0] step;
    logic [PWM_W-1:0]  level;
    logic              mode_change;
    logic              lit;
    logic [DUTY_W-1:0] duty_nxt;
    logic              dir_nxt;
    logic              peak_nxt;

    // A write lands its rate on the same edge, so the step taken on the
    // write edge already uses the new rate. A changed mode restarts the ramp
    // while a rate-only write keeps the ramp position. The clamps at MAX and
    // zero mean the accumulator can never wrap; OFF/ON park the ramp.
    always_comb begin
        eff_rate    = i_we ? i_rate : rate;
        step        = DUTY_W'(1) << eff_rate;
        level       = duty[DUTY_W-1 -: PWM_W];
        mode_change = i_we && (i_mode != mode);
        duty_nxt    = duty;
        dir_nxt     = dir_down;
        peak_nxt    = 1'b0;

        case (mode)
            MODE_OFF:    lit = 1'b0;
            MODE_ON:     lit = 1'b1;
            MODE_BREATH: lit = (level > i_cnt);
            default:     lit = dir_down;
        endcase

        if (i_sync || mode_change) begin
            duty_nxt = START;
            dir_nxt  = 1'b0;
        end else if (mode == MODE_BREATH || mode == MODE_BLINK) begin
            if (!dir_down) begin
                if ((MAX - duty) <= step) begin
                    duty_nxt = MAX;
                    dir_nxt  = 1'b1;
                    peak_nxt = 1'b1;
                end else begin
                    duty_nxt = duty + step;
                end
            end else begin
                if (duty <= step) begin
                    duty_nxt = '0;
                    dir_nxt  = 1'b0;
                end else begin
                    duty_nxt = duty - step;
                end
            end
        end else begin
            duty_nxt = '0;
            dir_nxt  = 1'b0;
        end
    end

    // Channel state register. The pin is the lit decision of the current
    // duty/cnt, registered, so it trails the ramp by one cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mode     <= MODE_BREATH;
            rate     <= '0;
            duty     <= START;
            dir_down <= 1'b0;
            o_peak   <= 1'b0;
            o_led    <= LOW_ON;
        end else begin
            if (i_we) begin
                mode <= i_mode;
                rate <= i_rate;
            end
            duty     <= duty_nxt;
            dir_down <= dir_nxt;
            o_peak   <= peak_nxt;
            o_led    <= lit ^ LOW_ON;
        end
    end

endmodule

// File: rtl/breath_led_array.sv
// ---------------------------------------------------------------------------
// breath_led_array
// Multi-channel PWM LED driver for board status LEDs.
//   i_clk      : system clock
//   i_rst      : synchronous reset, active high
//   i_sync     : realign all ramps and the PWM counter
//   i_cfg_we   : config write strobe
//   i_cfg_ch   : target channel (out-of-range writes are ignored)
//   i_cfg_mode : 00 OFF, 01 ON, 10 BREATH, 11 BLINK
//   i_cfg_rate : ramp rate exponent
//   o_led      : LED pins, registered
//   o_peak     : one-cycle pulse per channel when its ramp reaches MAX
// ---------------------------------------------------------------------------
module breath_led_array
    import breath_led_pkg::*;
#(
    parameter int CH_NUM       = 4,
    parameter int PWM_W        = 8,
    parameter int DUTY_W       = 21,
    parameter int RATE_W       = 4,
    parameter int ACTIVE_LOW   = 1,
    parameter int PHASE_SPREAD = 0,
    localparam int CH_W        = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sync,
    input  logic              i_cfg_we,
    input  logic [CH_W-1:0]   i_cfg_ch,
    input  logic [1:0]        i_cfg_mode,
    input  logic [RATE_W-1:0] i_cfg_rate,
    output logic [CH_NUM-1:0] o_led,
    output logic [CH_NUM-1:0] o_peak
);

    logic [PWM_W-1:0] cnt;

    // Free-running PWM counter shared by every channel; sync snaps it to zero
    // so all channels restart their PWM period together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (i_sync) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PWM_W'(1);
        end
    end

    // One channel instance per LED. A channel index that does not exist never
    // matches any k, which is how out-of-range writes get dropped.
    for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
        localparam logic [DUTY_W-1:0] START =
            DUTY_W'(start_value(k, CH_NUM, DUTY_W, PHASE_SPREAD != 0));

        logic wr;
        assign wr = i_cfg_we && (i_cfg_ch == CH_W'(k));

        breath_led_chan #(
            .PWM_W      (PWM_W),
            .DUTY_W     (DUTY_W),
            .RATE_W     (RATE_W),
            .ACTIVE_LOW (ACTIVE_LOW),
            .START      (START)
        ) u_chan (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_sync (i_sync),
            .i_cnt  (cnt),
            .i_we   (wr),
            .i_mode (i_cfg_mode),
            .i_rate (i_cfg_rate),
            .o_led  (o_led[k]),
            .o_peak (o_peak[k])
        );
    end

endmodule

// File: tb/tb_breath_led_array.sv
// ---------------------------------------------------------------------------
// tb_breath_led_array
// Three instances share one clock: dut 0 (4 ch), dut 1 (3 ch, out-of-range
// channel writes) and dut 2 (4 ch, phase spread). A behavioural model of the
// ramp/lit rules predicts every pin and peak each cycle.
// ---------------------------------------------------------------------------
module tb_breath_led_array;

    localparam int PWM_W  = 4;
    localparam int DUTY_W = 10;
    localparam int RATE_W = 4;
    localparam int MAXV   = (1 << DUTY_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]        rst;
    logic [2:0]        sync;
    logic [2:0]        we;
    logic [1:0]        cfg_ch   [3];
    logic [1:0]        cfg_mode [3];
    logic [RATE_W-1:0] cfg_rate [3];

    logic [3:0] led_a, peak_a, led_c, peak_c;
    logic [2:0] led_b, peak_b;

    breath_led_array #(.CH_NUM(4), .PWM_W(PWM_W), .DUTY_W(DUTY_W), .RATE_W(RATE_W),
                       .ACTIVE_LOW(1), .PHASE_SPREAD(0)) dut_a (
        .i_clk(clk), .i_rst(rst[0]), .i_sync(sync[0]), .i_cfg_we(we[0]),
        .i_cfg_ch(cfg_ch[0]), .i_cfg_mode(cfg_mode[0]), .i_cfg_rate(cfg_rate[0]),
        .o_led(led_a), .o_peak(peak_a));

    breath_led_array #(.CH_NUM(3), .PWM_W(PWM_W), .DUTY_W(DUTY_W), .RATE_W(RATE_W),
                       .ACTIVE_LOW(1), .PHASE_SPREAD(0)) dut_b (
        .i_clk(clk), .i_rst(rst[1]), .i_sync(sync[1]), .i_cfg_we(we[1]),
        .i_cfg_ch(cfg_ch[1]), .i_cfg_mode(cfg_mode[1]), .i_cfg_rate(cfg_rate[1]),
        .o_led(led_b), .o_peak(peak_b));

    breath_led_array #(.CH_NUM(4), .PWM_W(PWM_W), .DUTY_W(DUTY_W), .RATE_W(RATE_W),
                       .ACTIVE_LOW(1), .PHASE_SPREAD(1)) dut_c (
        .i_clk(clk), .i_rst(rst[2]), .i_sync(sync[2]), .i_cfg_we(we[2]),
        .i_cfg_ch(cfg_ch[2]), .i_cfg_mode(cfg_mode[2]), .i_cfg_rate(cfg_rate[2]),
        .o_led(led_c), .o_peak(peak_c));

    int total = 0;
    int bad   = 0;
    int edge_num = 0;

    // Reference model state, one row per dut
    int m_duty [3][4];
    int m_down [3][4];
    int m_mode [3][4];
    int m_rate [3][4];
    int m_led  [3][4];
    int m_peak [3][4];
    int m_cnt  [3];

    int q_peak_a0[$];
    int q_peak_a1[$];
    int q_tog_a3[$];
    int q_peak_c0[$];
    logic prev_a3 = 1'b1;

    function automatic int ch_count(input int d);
        return (d == 1) ? 3 : 4;
    endfunction

    function automatic int start_of(input int d, input int k);
        return (d == 2) ? k * ((MAXV + 1) / 4) : 0;
    endfunction

    // Model: one clock edge of dut d, from the behavioural rules
    task automatic modelStep(input int d);
        int n, step, er, lit;
        bit wr, restart;
        n = ch_count(d);
        for (int k = 0; k < n; k++) begin
            case (m_mode[d][k])
                0:       lit = 0;
                1:       lit = 1;
                2:       lit = ((m_duty[d][k] >> (DUTY_W - PWM_W)) > m_cnt[d]) ? 1 : 0;
                default: lit = m_down[d][k];
            endcase
            if (rst[d]) begin
                m_mode[d][k] = 2; m_rate[d][k] = 0; m_down[d][k] = 0;
                m_duty[d][k] = start_of(d, k); m_peak[d][k] = 0; m_led[d][k] = 1;
            end else begin
                m_led[d][k]  = 1 - lit;
                m_peak[d][k] = 0;
                wr      = we[d] && (int'(cfg_ch[d]) == k);
                er      = wr ? int'(cfg_rate[d]) : m_rate[d][k];
                step    = 1 << er;
                restart = sync[d] || (wr && int'(cfg_mode[d]) != m_mode[d][k]);
                if (restart) begin
                    m_duty[d][k] = start_of(d, k); m_down[d][k] = 0;
                end else if (m_mode[d][k] >= 2) begin
                    if (m_down[d][k] == 0) begin
                        if (MAXV - m_duty[d][k] <= step) begin
                            m_duty[d][k] = MAXV; m_down[d][k] = 1; m_peak[d][k] = 1;
                        end else m_duty[d][k] += step;
                    end else begin
                        if (m_duty[d][k] <= step) begin
                            m_duty[d][k] = 0; m_down[d][k] = 0;
                        end else m_duty[d][k] -= step;
                    end
                end else begin
                    m_duty[d][k] = 0; m_down[d][k] = 0;
                end
                if (wr) begin
                    m_mode[d][k] = int'(cfg_mode[d]);
                    m_rate[d][k] = int'(cfg_rate[d]);
                end
            end
        end
        if (rst[d] || sync[d]) m_cnt[d] = 0;
        else m_cnt[d] = (m_cnt[d] + 1) % (1 << PWM_W);
    endtask

    // The model advances on the same edge as the DUTs; inputs only change on
    // the falling edge, so both see identical values.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) modelStep(d);
    end

    task automatic checkValue(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s edge=%0d observed=%0d expected=%0d", tag, edge_num, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic [3:0] obs_led, obs_peak, exp_led, exp_peak;
        for (int d = 0; d < 3; d++) begin
            exp_led = '0; exp_peak = '0;
            for (int k = 0; k < ch_count(d); k++) begin
                exp_led[k]  = m_led[d][k][0];
                exp_peak[k] = m_peak[d][k][0];
            end
            case (d)
                0:       begin obs_led = led_a;         obs_peak = peak_a;         end
                1:       begin obs_led = {1'b0, led_b}; obs_peak = {1'b0, peak_b}; end
                default: begin obs_led = led_c;         obs_peak = peak_c;         end
            endcase
            total++;
            assert (obs_led === exp_led) else begin
                bad++;
                $error("[TB] FAIL led dut%0d edge=%0d observed=%b expected=%b", d, edge_num, obs_led, exp_led);
            end
            total++;
            assert (obs_peak === exp_peak) else begin
                bad++;
                $error("[TB] FAIL peak dut%0d edge=%0d observed=%b expected=%b", d, edge_num, obs_peak, exp_peak);
            end
        end
        if (peak_a[0] === 1'b1) q_peak_a0.push_back(edge_num);
        if (peak_a[1] === 1'b1) q_peak_a1.push_back(edge_num);
        if (peak_c[0] === 1'b1) q_peak_c0.push_back(edge_num);
        if (led_a[3] !== prev_a3) q_tog_a3.push_back(edge_num);
        prev_a3 = led_a[3];
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            edge_num++;
            checkOutput();
        end
    endtask

    task automatic applyStimulus(input int d, input bit r, input bit s, input bit w,
                                 input int ch, input int mode, input int rate);
        rst[d]      = r;
        sync[d]     = s;
        we[d]       = w;
        cfg_ch[d]   = 2'(ch);
        cfg_mode[d] = 2'(mode);
        cfg_rate[d] = RATE_W'(rate);
    endtask

    function automatic int qget(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    int w_edge, s_edge;

    initial begin
        for (int d = 0; d < 3; d++) applyStimulus(d, 1, 0, 0, 0, 0, 0);

        // Reset held for three edges: all pins dark, no peaks
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput();
            checkValue("rst_led_a", int'(led_a), 15);
            checkValue("rst_peak_a", int'(peak_a), 0);
        end
        $display("[TB] releasing reset, ch1 rate=3 on first edge");
        for (int d = 0; d < 3; d++) applyStimulus(d, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 1, 2, 3);
        edge_num = 0;
        runCycles(1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        runCycles(5199);
        checkValue("peak_a0_1st", qget(q_peak_a0, 0), 1023);
        checkValue("peak_a0_2nd", qget(q_peak_a0, 1), 3069);
        checkValue("peak_a0_3rd", qget(q_peak_a0, 2), 5115);
        checkValue("peak_a1_1st", qget(q_peak_a1, 0), 128);
        checkValue("peak_a1_2nd", qget(q_peak_a1, 1), 384);
        checkValue("peak_a1_3rd", qget(q_peak_a1, 2), 640);

        $display("[TB] OFF / ON / BLINK modes");
        applyStimulus(0, 0, 0, 1, 2, 0, 0);
        runCycles(1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        runCycles(2);
        for (int i = 0; i < 20; i++) begin
            runCycles(1);
            checkValue("off_pin", int'(led_a[2]), 1);
        end
        applyStimulus(0, 0, 0, 1, 2, 1, 5);
        runCycles(1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        runCycles(2);
        for (int i = 0; i < 20; i++) begin
            runCycles(1);
            checkValue("on_pin", int'(led_a[2]), 0);
        end
        applyStimulus(0, 0, 0, 1, 3, 3, 0);
        runCycles(1);
        w_edge = edge_num;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        runCycles(2);
        q_tog_a3.delete();
        runCycles(3200);
        checkValue("blink_first", qget(q_tog_a3, 0) - w_edge, 1024);
        checkValue("blink_half1", qget(q_tog_a3, 1) - qget(q_tog_a3, 0), 1023);
        checkValue("blink_half2", qget(q_tog_a3, 2) - qget(q_tog_a3, 1), 1023);

        $display("[TB] out-of-range channel on 3-channel instance");
        applyStimulus(1, 0, 0, 1, 2, 0, 0);
        runCycles(1);
        applyStimulus(1, 0, 0, 1, 3, 1, 7);
        runCycles(1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            runCycles(1);
            checkValue("oor_ch2_dark", int'(led_b[2]), 1);
        end
        runCycles(100);

        $display("[TB] sync with same-edge write, then reset mid-ramp");
        q_peak_c0.delete();
        applyStimulus(2, 0, 1, 1, 0, 2, 2);
        runCycles(1);
        s_edge = edge_num;
        checkValue("sync_peak", int'(peak_c), 0);
        applyStimulus(2, 0, 0, 0, 0, 0, 0);
        runCycles(1);
        checkValue("sync_led", int'(led_c), 1);
        runCycles(300);
        checkValue("sync_ch0_peak", qget(q_peak_c0, 0) - s_edge, 256);
        applyStimulus(2, 1, 0, 0, 0, 0, 0);
        runCycles(1);
        checkValue("midrst_led", int'(led_c), 15);
        checkValue("midrst_peak", int'(peak_c), 0);
        applyStimulus(2, 0, 0, 0, 0, 0, 0);
        runCycles(50);

        $display("[TB] randomized config traffic");
        for (int i = 0; i < 6000; i++) begin
            for (int d = 0; d < 3; d++) begin
                applyStimulus(d, ($urandom % 1500) == 0, ($urandom % 700) == 0,
                              ($urandom % 8) == 0, int'($urandom % 4),
                              int'($urandom % 4), int'($urandom_range(0, DUTY_W - 1)));
            end
            runCycles(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
